instr_fetch_unit: RTL and testbench

Instruction fetch front end for the simple CPU. It owns the program counter, drives word addresses into the combinational instruction memory, and reads back 32-bit instruction words. It buffers fetched words with their PCs in a small prefetch FIFO and hands them to decode through a valid/ready handshake. A redirect from execute flushes the FIFO and restarts fetch at the branch target.

---
 rtl/instr_fetch_unit_if.sv | 46 ++++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit bus bundle: imem port, decode handshake, redirect
//
// Signals:
//   imem_addr      fetch byte address to instruction memory (word aligned)
//   imem_data      instruction word, combinational from imem_addr
//   instr_valid    head prefetch entry is presented to decode
//   instr_ready    decode accepts the presented entry
//   instr_data     instruction word of head entry
//   instr_pc       PC of head entry
//   redirect_valid flush prefetch and restart at redirect_pc
//   redirect_pc    restart target (bits [1:0] ignored)
// Modports:
//   master  fetch unit side
//   slave   memory / decode / execute side
interface instr_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch front end with prefetch FIFO and redirect
//
// Ports:
//   clk             clock, all state updates on rising edge
//   rst_n           asynchronous active-low reset
//   bus             instr_fetch_unit_if.master (imem port, decode handshake, redirect)
//   perf_fetch_cnt  (FETCH_PERF_EN only) pushes into the prefetch FIFO, wraps
//   perf_stall_cnt  (FETCH_PERF_EN only) cycles with no push and no redirect, wraps
// Parameters:
//   RESET_PC        word-aligned PC after reset
//   FIFO_DEPTH      prefetch entries, power of two, >= 2
// Optional feature macro: FETCH_PERF_EN
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    instr_fetch_unit_if.master      bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]             perf_fetch_cnt,
    output logic [31:0]             perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc_q;
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [31:0]      fifo_word [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic pop;
    logic push;

    // Redirect masks valid in the same cycle so decode never consumes a
    // wrong-path entry while the flush is happening.
    assign bus.instr_valid = (count != '0) && !bus.redirect_valid;
    assign bus.instr_data  = fifo_word[rd_ptr];
    assign bus.instr_pc    = fifo_pc[rd_ptr];
    assign bus.imem_addr   = pc_q;

    assign pop  = bus.instr_valid && bus.instr_ready;
    // A pop frees the head slot this cycle, so a full FIFO can still accept.
    assign push = !bus.redirect_valid && ((count < FULL_CNT) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_word[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            pc_q   <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]   <= pc_q;
                fifo_word[wr_ptr] <= bus.imem_data;
                wr_ptr            <= wr_ptr + 1'b1;
                pc_q              <= pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (!push && !bus.redirect_valid) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    instr_fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.master)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Instruction memory: word at address a is {~a[15:0], a[15:0]}
    assign bus.imem_data = {~bus.imem_addr[15:0], bus.imem_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // reset state
        #1;
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("rst_data", bus.instr_data, 32'h0);
        chk("rst_pc", bus.instr_pc, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // streaming with ready=1
        tick();
        chk("s0_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("s0_pc", bus.instr_pc, 32'h0);
        chk("s0_data", bus.instr_data, 32'hFFFF_0000);
        chk("s0_imem_addr", bus.imem_addr, 32'h4);
        tick();
        chk("s1_pc", bus.instr_pc, 32'h4);
        chk("s1_data", bus.instr_data, 32'hFFFB_0004);
        tick();
        chk("s2_pc", bus.instr_pc, 32'h8);
        tick();
        chk("s3_pc", bus.instr_pc, 32'hC);
        chk("s3_valid", {31'b0, bus.instr_valid}, 32'h1);

        // backpressure from reset
        rst_n = 1'b0;
        bus.instr_ready = 1'b0;
        #1;
        chk("bp_rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("bp_rst_addr", bus.imem_addr, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("bp_c1_addr", bus.imem_addr, 32'h4);
        chk("bp_c1_pc", bus.instr_pc, 32'h0);
        tick();
        chk("bp_c2_addr", bus.imem_addr, 32'h8);
        tick();
        chk("bp_c3_addr", bus.imem_addr, 32'h8);
        tick();
        chk("bp_c4_addr", bus.imem_addr, 32'h8);
        tick();
        chk("bp_c5_addr", bus.imem_addr, 32'h8);
        chk("bp_c5_pc", bus.instr_pc, 32'h0);
        bus.instr_ready = 1'b1;
        tick();
        chk("bp_d1_pc", bus.instr_pc, 32'h4);
        chk("bp_d1_addr", bus.imem_addr, 32'hC);
        tick();
        chk("bp_d2_pc", bus.instr_pc, 32'h8);
        chk("bp_d2_data", bus.instr_data, 32'hFFF7_0008);

        // redirect to 0x40 with two entries held and ready=1
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1;
        chk("rd40_same_valid", {31'b0, bus.instr_valid}, 32'h0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("rd40_n1_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("rd40_n1_addr", bus.imem_addr, 32'h40);
        tick();
        chk("rd40_n2_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("rd40_n2_pc", bus.instr_pc, 32'h40);
        chk("rd40_n2_data", bus.instr_data, 32'hFFBF_0040);
        tick();
        chk("rd40_n3_pc", bus.instr_pc, 32'h44);

        // unaligned redirect target is forced to word alignment
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h43;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("rd43_addr", bus.imem_addr, 32'h40);
        tick();
        chk("rd43_pc", bus.instr_pc, 32'h40);

        // wrap of the PC at the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        chk("wrap_pc0", bus.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_data0", bus.instr_data, 32'h0003_FFFC);
        tick();
        chk("wrap_pc1", bus.instr_pc, 32'h0000_0000);
        tick();
        chk("wrap_pc2", bus.instr_pc, 32'h0000_0004);

        // fill the FIFO, then reset asynchronously between edges
        bus.instr_ready = 1'b0;
        tick();
        chk("full_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("full_addr", bus.imem_addr, 32'hC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("async_addr", bus.imem_addr, 32'h0);
        chk("async_pc", bus.instr_pc, 32'h0);
`ifdef FETCH_PERF_EN
        chk("async_perf_fetch", perf_fetch_cnt, 32'h0);
        chk("async_perf_stall", perf_stall_cnt, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
